// File: rtl/aes_mixcolumns_serial.sv
// MixColumns / InvMixColumns engine for a full 128-bit AES state, LANES columns per cycle.
// Decrypt pre-multiplies by the 05/04 decomposition and reuses the MixColumns datapath.
module aes_mixcolumns_serial #(
  parameter int LANES = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic         in_enc_dec,
  input  logic         in_bypass,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  generate
    if (LANES != 1 && LANES != 2 && LANES != 4) begin : g_bad_lanes
      $error("aes_mixcolumns_serial: LANES must be 1, 2 or 4");
    end
  endgenerate

  state_t            r_fsm;
  state_t            w_fsm_nxt;
  logic [0:3][31:0]  r_data;
  logic [0:3][31:0]  r_result;
  logic              r_enc;
  logic [1:0]        r_col;
  logic              w_accept;
  logic              w_last;
  logic [1:0]        w_idx [LANES];
  logic [31:0]       w_mix [LANES];

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3, t;
    a0 = c[31:24];
    a1 = c[23:16];
    a2 = c[15:8];
    a3 = c[7:0];
    t  = a0 ^ a1 ^ a2 ^ a3;
    return {a0 ^ t ^ xtime(a0 ^ a1),
            a1 ^ t ^ xtime(a1 ^ a2),
            a2 ^ t ^ xtime(a2 ^ a3),
            a3 ^ t ^ xtime(a3 ^ a0)};
  endfunction

  // Multiply by [05 00 04 00; 00 05 00 04; 04 00 05 00; 00 04 00 05]: a ^ 04*(pair xor).
  function automatic logic [31:0] inv_pre(input logic [31:0] c);
    logic [7:0] u, v;
    u = xtime(xtime(c[31:24] ^ c[15:8]));
    v = xtime(xtime(c[23:16] ^ c[7:0]));
    return {c[31:24] ^ u, c[23:16] ^ v, c[15:8] ^ u, c[7:0] ^ v};
  endfunction

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [31:0] w_col;
    logic [31:0] w_pre;
    assign w_idx[l] = r_col + 2'(l);
    assign w_col    = r_data[w_idx[l]];
    assign w_pre    = r_enc ? w_col : inv_pre(w_col);
    assign w_mix[l] = mix_col(w_pre);
  end

  assign w_accept  = in_valid & in_ready;
  assign w_last    = (int'(r_col) + LANES == 4);
  assign out_valid = (r_fsm == S_DONE);
  assign busy      = (r_fsm != S_IDLE);
  assign out_state = r_result;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fsm <= S_IDLE;
    end else begin
      r_fsm <= w_fsm_nxt;
    end
  end

  always_comb begin
    w_fsm_nxt = r_fsm;
    in_ready  = 1'b0;
    case (r_fsm)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_fsm_nxt = in_bypass ? S_DONE : S_RUN;
      end
      S_RUN: begin
        if (w_last) w_fsm_nxt = S_DONE;
      end
      S_DONE: begin
        in_ready = out_ready;
        if (out_ready) begin
          if (in_valid) w_fsm_nxt = in_bypass ? S_DONE : S_RUN;
          else          w_fsm_nxt = S_IDLE;
        end
      end
      default: w_fsm_nxt = S_IDLE;
    endcase
    if (rst) in_ready = 1'b0;
  end

  // r_data is only loaded on acceptance, so it cannot change while columns are in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data   <= '0;
      r_result <= '0;
      r_enc    <= 1'b0;
      r_col    <= 2'd0;
    end else if (w_accept) begin
      r_data <= in_state;
      r_enc  <= in_enc_dec;
      r_col  <= 2'd0;
      if (in_bypass) r_result <= in_state;
    end else if (r_fsm == S_RUN) begin
      for (int l = 0; l < LANES; l++) begin
        r_result[w_idx[l]] <= w_mix[l];
      end
      r_col <= r_col + 2'(LANES);
    end
  end

endmodule

// File: tb/tb_aes_mixcolumns_serial.sv
// Bench for aes_mixcolumns_serial: one instance per legal LANES value, directed vectors
// plus randomized transactions against a matrix-level GF(2^8) reference model.
module tb_aes_mixcolumns_serial;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst;
  logic [2:0]          in_valid;
  logic [2:0]          in_enc_dec;
  logic [2:0]          in_bypass;
  logic [2:0]          out_ready;
  logic [2:0][127:0]   in_state;
  wire  [2:0]          in_ready;
  wire  [2:0]          out_valid;
  wire  [2:0]          busy;
  wire  [2:0][127:0]   out_state;

  int n_total = 0;
  int n_bad   = 0;

  aes_mixcolumns_serial #(.LANES(1)) u_l1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_state(in_state[0]), .in_enc_dec(in_enc_dec[0]), .in_bypass(in_bypass[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_state(out_state[0]),
    .busy(busy[0]));

  aes_mixcolumns_serial #(.LANES(2)) u_l2 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_state(in_state[1]), .in_enc_dec(in_enc_dec[1]), .in_bypass(in_bypass[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_state(out_state[1]),
    .busy(busy[1]));

  aes_mixcolumns_serial #(.LANES(4)) u_l4 (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_state(in_state[2]), .in_enc_dec(in_enc_dec[2]), .in_bypass(in_bypass[2]),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_state(out_state[2]),
    .busy(busy[2]));

  function automatic int lanes_of(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 2 : 4);
  endfunction

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Circulant matrices: MixColumns {02 03 01 01}, InvMixColumns {0e 0b 0d 09}.
  function automatic logic [127:0] ref_mix(input logic [127:0] s, input logic enc, input logic byp);
    logic [127:0] r;
    logic [7:0]   a [4];
    logic [7:0]   base [4];
    logic [7:0]   acc;
    if (byp) return s;
    if (enc) base = '{8'h02, 8'h03, 8'h01, 8'h01};
    else     base = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    r = '0;
    for (int j = 0; j < 4; j++) begin
      for (int i = 0; i < 4; i++) a[i] = s[127-32*j-8*i -: 8];
      for (int i = 0; i < 4; i++) begin
        acc = 8'h00;
        for (int c = 0; c < 4; c++) acc ^= gmul(base[(c - i + 4) % 4], a[c]);
        r[127-32*j-8*i -: 8] = acc;
      end
    end
    return r;
  endfunction

  // One full transaction on instance k; lat is the first cycle with out_valid (acceptance = 0).
  task automatic send(input int k, input logic [127:0] st, input logic enc, input logic byp,
                      input int rdy_pct, output logic [127:0] res, output int lat,
                      output logic [31:0] bmask);
    int  n;
    bit  done;
    in_state[k]   = st;
    in_enc_dec[k] = enc;
    in_bypass[k]  = byp;
    in_valid[k]   = 1'b1;
    res   = '0;
    lat   = 0;
    bmask = '0;
    done  = 1'b0;
    n     = 0;
    @(negedge clk);
    while (!in_ready[k] && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready[k]) begin
      check_val("accept_timeout", 1'b0, 1'b1);
      in_valid[k] = 1'b0;
      return;
    end
    bmask[0] = busy[k];
    @(posedge clk); #1;
    in_valid[k]   = 1'b0;
    in_state[k]   = {$urandom, $urandom, $urandom, $urandom};
    in_enc_dec[k] = 1'($urandom_range(1));
    in_bypass[k]  = 1'($urandom_range(1));
    for (int c = 1; c <= 40 && !done; c++) begin
      out_ready[k] = ($urandom_range(99) < rdy_pct);
      @(negedge clk);
      if (c < 32) bmask[c] = busy[k];
      if (lat != 0) begin
        check_val("valid_held", out_valid[k], 1'b1);
        check_val("state_held", out_state[k], res);
      end else if (out_valid[k]) begin
        lat = c;
        res = out_state[k];
      end
      if (out_valid[k] && out_ready[k]) done = 1'b1;
      @(posedge clk); #1;
    end
    out_ready[k] = 1'b0;
    in_bypass[k] = 1'b0;
    if (!done) check_val("handshake_timeout", 1'b0, 1'b1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] res, res2, st, st2, exp;
    logic [31:0]  bmask;
    int           lat;
    logic         enc, byp;

    rst        = 1'b1;
    in_valid   = '0;
    in_enc_dec = '0;
    in_bypass  = '0;
    out_ready  = '0;
    in_state   = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check_val("rst_in_ready", in_ready, 3'b000);
    check_val("rst_out_valid", out_valid, 3'b000);
    check_val("rst_busy", busy, 3'b000);
    for (int k = 0; k < 3; k++) check_val("rst_out_state", out_state[k], '0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_val("post_rst_in_ready", in_ready, 3'b111);
    @(posedge clk); #1;

    // Encrypt, LANES=1
    send(0, 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5, 1'b1, 1'b0, 100, res, lat, bmask);
    check_val("enc_l1_data", res, 128'h046681e5_e0cb199a_48f8d37a_2806264c);
    check_val("enc_l1_lat", lat, 5);
    check_val("enc_l1_busy", bmask[5:0], 6'b111110);

    // Decrypt, LANES=4
    send(2, 128'h046681e5_e0cb199a_48f8d37a_2806264c, 1'b0, 1'b0, 100, res, lat, bmask);
    check_val("dec_l4_data", res, 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5);
    check_val("dec_l4_lat", lat, 2);

    // Per-column vectors on every lane count
    for (int k = 0; k < 3; k++) begin
      send(k, 128'hdb135345_01010101_c6c6c6c6_db135345, 1'b1, 1'b0, 100, res, lat, bmask);
      check_val("col_enc", res, 128'h8e4da1bc_01010101_c6c6c6c6_8e4da1bc);
      send(k, 128'h8e4da1bc_01010101_c6c6c6c6_8e4da1bc, 1'b0, 1'b0, 100, res, lat, bmask);
      check_val("col_dec", res, 128'hdb135345_01010101_c6c6c6c6_db135345);
    end

    // Bypass, LANES=2, both mode bits
    for (int m = 0; m < 2; m++) begin
      st = {$urandom, $urandom, $urandom, $urandom};
      send(1, st, 1'(m), 1'b1, 100, res, lat, bmask);
      check_val("byp_data", res, st);
      check_val("byp_lat", lat, 1);
    end

    // Backpressure then same-cycle handoff, LANES=2
    st  = {$urandom, $urandom, $urandom, $urandom};
    st2 = {$urandom, $urandom, $urandom, $urandom};
    exp = ref_mix(st, 1'b1, 1'b0);
    in_state[1] = st; in_enc_dec[1] = 1'b1; in_bypass[1] = 1'b0; in_valid[1] = 1'b1;
    out_ready[1] = 1'b0;
    @(negedge clk);
    check_val("bp_accept_a", in_ready[1], 1'b1);
    @(posedge clk); #1;
    in_valid[1] = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    @(negedge clk);
    check_val("bp_valid_c3", out_valid[1], 1'b1);
    check_val("bp_data_a", out_state[1], exp);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check_val("bp_valid_hold", out_valid[1], 1'b1);
      check_val("bp_state_hold", out_state[1], exp);
    end
    @(posedge clk); #1;
    out_ready[1] = 1'b1; in_valid[1] = 1'b1; in_state[1] = st2; in_enc_dec[1] = 1'b0;
    @(negedge clk);
    check_val("bp_handoff_ready", in_ready[1], 1'b1);
    @(posedge clk); #1;
    in_valid[1] = 1'b0; out_ready[1] = 1'b0;
    in_state[1] = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    check_val("bp_b_running", out_valid[1], 1'b0);
    repeat (2) begin @(posedge clk); #1; end
    @(negedge clk);
    check_val("bp_b_valid_c3", out_valid[1], 1'b1);
    check_val("bp_data_b", out_state[1], ref_mix(st2, 1'b0, 1'b0));
    @(posedge clk); #1;
    out_ready[1] = 1'b1;
    @(posedge clk); #1;
    out_ready[1] = 1'b0;

    // Reset mid-RUN, LANES=1
    in_state[0] = {$urandom, $urandom, $urandom, $urandom};
    in_enc_dec[0] = 1'b1; in_bypass[0] = 1'b0; in_valid[0] = 1'b1;
    @(negedge clk);
    check_val("mr_accept", in_ready[0], 1'b1);
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check_val("mr_in_ready_in_rst", in_ready[0], 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_val("mr_out_valid", out_valid[0], 1'b0);
    check_val("mr_out_state", out_state[0], '0);
    check_val("mr_busy", busy[0], 1'b0);
    check_val("mr_in_ready", in_ready[0], 1'b1);
    @(posedge clk); #1;
    st = {$urandom, $urandom, $urandom, $urandom};
    send(0, st, 1'b0, 1'b0, 100, res, lat, bmask);
    check_val("mr_fresh_data", res, ref_mix(st, 1'b0, 1'b0));
    check_val("mr_fresh_lat", lat, 5);

    // Randomized transactions with round-trip spot checks
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 1000; i++) begin
        st  = {$urandom, $urandom, $urandom, $urandom};
        byp = ($urandom_range(9) == 0);
        enc = 1'($urandom_range(1));
        send(k, st, enc, byp, 60, res, lat, bmask);
        check_val("rand_data", res, ref_mix(st, enc, byp));
        check_val("rand_lat", lat, byp ? 1 : 4 / lanes_of(k) + 1);
        if (i % 25 == 0) begin
          send(k, st, 1'b1, 1'b0, 100, res, lat, bmask);
          send(k, res, 1'b0, 1'b0, 100, res2, lat, bmask);
          check_val("round_trip", res2, st);
        end
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
